// File: rtl/pipe_decoder_pkg.sv
// Shared opcode, FS/BS encodings and width helpers
// for the pipelined instruction decode stage.
package pipe_decoder_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b0010;
  localparam logic [3:0] OP_SB   = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_ANDI = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BGEZ = 4'b1010;
  localparam logic [3:0] OP_BLTZ = 4'b1011;
  localparam logic [3:0] OP_RTYP = 4'b1111;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_AND = 3'b101;
  localparam logic [2:0] FS_OR  = 3'b110;

  localparam logic [2:0] BS_NONE = 3'b111;
  localparam logic [2:0] FN_HLT  = 3'b001;

  function automatic int inst_w(input int aw);
    return 3 * aw + 7;
  endfunction

  function automatic int imm_w(input int aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/pipe_decoder_scoreboard.sv
// Per-register pending bits for in-flight writes
// and the RAW/WAW hazard query against them.
module pipe_decoder_scoreboard #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              held_ld,
  input  logic [REG_AW-1:0] held_dr,
  input  logic              sa_used,
  input  logic [REG_AW-1:0] sa,
  input  logic              sb_used,
  input  logic [REG_AW-1:0] sb,
  input  logic              dr_used,
  input  logic [REG_AW-1:0] dr,
  output logic              hazard
);

  localparam int N = 2 ** REG_AW;

  logic [N-1:0] pend;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] busy;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_addr] = 1'b1;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
    // a retiring write no longer blocks; a held LD bundle always does
    busy = pend & ~clr_vec;
    if (held_ld) busy[held_dr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

  assign hazard = (sa_used & busy[sa])
                | (sb_used & busy[sb])
                | (dr_used & busy[dr]);

endmodule

// File: rtl/pipe_decoder.sv
// Decode stage: splits the instruction word into a registered
// control bundle with valid/ready handshake and hazard stalls.
module pipe_decoder
  import pipe_decoder_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int DATA_W   = 16,
  parameter int SEXT_IMM = 1,
  localparam int INST_W  = inst_w(REG_AW),
  localparam int IW      = imm_w(REG_AW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] DR,
  output logic [REG_AW-1:0] SA,
  output logic [REG_AW-1:0] SB,
  output logic [DATA_W-1:0] IMM,
  output logic [DATA_W-1:0] OFF,
  output logic [2:0]        FS,
  output logic [2:0]        BS,
  output logic              MB,
  output logic              MD,
  output logic              LD,
  output logic              MW,
  output logic              HLT,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dr,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [REG_AW-1:0] dr;
    logic [REG_AW-1:0] sa;
    logic [REG_AW-1:0] sb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] off;
    logic [2:0]        fs;
    logic [2:0]        bs;
    logic              mb;
    logic              md;
    logic              ld;
    logic              mw;
    logic              hlt;
  } bundle_t;

  logic [3:0]        op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [2:0]        funct;
  logic [IW-1:0]     raw;
  logic [DATA_W-1:0] ext;
  bundle_t           dec;
  bundle_t           q;
  logic              sa_used;
  logic              sb_used;
  logic              hazard;
  logic              hs;
  logic              accept;

  assign op    = inst[INST_W-1 -: 4];
  assign rs    = inst[INST_W-5 -: REG_AW];
  assign rt    = inst[INST_W-5-REG_AW -: REG_AW];
  assign rd    = inst[REG_AW+2 -: REG_AW];
  assign funct = inst[2:0];
  assign raw   = inst[IW-1:0];

  always_comb begin
    ext = '0;
    if (SEXT_IMM != 0 && raw[IW-1]) ext = '1;
    ext[IW-1:0] = raw;
  end

  always_comb begin
    dec     = '0;
    dec.bs  = BS_NONE;
    dec.dr  = rd;
    dec.sa  = rs;
    dec.sb  = rt;
    dec.fs  = funct;
    dec.ld  = 1'b1;
    sa_used = 1'b1;
    sb_used = 1'b1;
    unique case (op)
      OP_NOP: begin
        dec.dr  = '0;
        dec.sa  = '0;
        dec.sb  = '0;
        dec.ld  = 1'b0;
        dec.hlt = (funct == FN_HLT);
        sa_used = 1'b0;
        sb_used = 1'b0;
      end
      OP_LB: begin
        dec.dr  = rt;
        dec.sb  = '0;
        dec.mb  = 1'b1;
        dec.fs  = FS_ADD;
        dec.md  = 1'b1;
        dec.imm = ext;
        sb_used = 1'b0;
      end
      OP_SB: begin
        dec.dr  = rt;
        dec.mb  = 1'b1;
        dec.fs  = FS_ADD;
        dec.ld  = 1'b0;
        dec.mw  = 1'b1;
        dec.imm = ext;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec.dr  = rt;
        dec.sb  = '0;
        dec.mb  = 1'b1;
        dec.fs  = (op == OP_ADDI) ? FS_ADD :
                  (op == OP_ANDI) ? FS_AND : FS_OR;
        dec.imm = ext;
        sb_used = 1'b0;
      end
      OP_BEQ, OP_BNE, OP_BGEZ, OP_BLTZ: begin
        dec.dr  = '0;
        dec.fs  = FS_SUB;
        dec.ld  = 1'b0;
        dec.mb  = (op == OP_BGEZ) || (op == OP_BLTZ);
        dec.bs  = {1'b0, op[1:0]};
        dec.off = ext;
      end
      default: begin
      end
    endcase
  end

  pipe_decoder_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (hs & q.ld),
    .set_addr (q.dr),
    .clr_en   (wb_valid),
    .clr_addr (wb_dr),
    .held_ld  (out_valid & q.ld),
    .held_dr  (q.dr),
    .sa_used  (sa_used),
    .sa       (dec.sa),
    .sb_used  (sb_used),
    .sb       (dec.sb),
    .dr_used  (dec.ld),
    .dr       (dec.dr),
    .hazard   (hazard)
  );

  assign hs       = out_valid & out_ready & ~flush;
  assign in_ready = ~halted & ~hazard & ~(out_valid & q.hlt)
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      q.bs      <= BS_NONE;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (hs)     out_valid <= 1'b0;
      if (accept) q <= dec;
      if (hs && q.hlt) halted <= 1'b1;
      if (in_valid && hazard && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign DR  = q.dr;
  assign SA  = q.sa;
  assign SB  = q.sb;
  assign IMM = q.imm;
  assign OFF = q.off;
  assign FS  = q.fs;
  assign BS  = q.bs;
  assign MB  = q.mb;
  assign MD  = q.md;
  assign LD  = q.ld;
  assign MW  = q.mw;
  assign HLT = q.hlt;

endmodule

// File: tb/tb_pipe_decoder.sv
// Scoreboard bench for pipe_decoder: random traffic against a
// behavioural model, plus directed corner scenarios.
module tb_pipe_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] inst;
  logic [2:0]  DR, SA, SB, FS, BS, wb_dr;
  logic [15:0] IMM, OFF, stall_cnt;
  logic        MB, MD, LD, MW, HLT, flush, wb_valid, halted;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [18:0] w_inst;
  logic [3:0]  w_DR, w_SA, w_SB, w_wb_dr;
  logic [31:0] w_IMM, w_OFF;
  logic [2:0]  w_FS, w_BS;
  logic        w_MB, w_MD, w_LD, w_MW, w_HLT, w_flush, w_wb_valid;
  logic        w_halted;
  logic [15:0] w_stall_cnt;

  pipe_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .DR(DR), .SA(SA), .SB(SB), .IMM(IMM), .OFF(OFF),
    .FS(FS), .BS(BS), .MB(MB), .MD(MD), .LD(LD), .MW(MW),
    .HLT(HLT), .flush(flush), .wb_valid(wb_valid),
    .wb_dr(wb_dr), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_decoder #(.REG_AW(4), .DATA_W(32), .SEXT_IMM(0)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .inst(w_inst),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .DR(w_DR), .SA(w_SA), .SB(w_SB), .IMM(w_IMM), .OFF(w_OFF),
    .FS(w_FS), .BS(w_BS), .MB(w_MB), .MD(w_MD), .LD(w_LD),
    .MW(w_MW), .HLT(w_HLT), .flush(w_flush),
    .wb_valid(w_wb_valid), .wb_dr(w_wb_dr),
    .halted(w_halted), .stall_cnt(w_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  dr, sa, sb;
    logic [15:0] imm, off;
    logic [2:0]  fs, bs;
    logic        mb, md, ld, mw, hlt, ua, ub;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   pend [8];
  bit   mv;
  exp_t mh;
  bit   mhalt;
  int   mstall;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic exp_t ref_decode(input logic [15:0] w);
    exp_t e;
    int op, rs, rt, rd, fn, sv;
    op = int'(w[15:12]);
    rs = int'(w[11:9]);
    rt = int'(w[8:6]);
    rd = int'(w[5:3]);
    fn = int'(w[2:0]);
    sv = int'(w[5:0]);
    if (sv > 31) sv = sv - 64;
    e = '0;
    e.bs = 3'd7;
    if (op == 0) begin
      e.fs = 3'(fn);
      e.hlt = (fn == 1);
    end else if (op == 2) begin
      e.dr = 3'(rt); e.sa = 3'(rs); e.mb = 1'b1; e.md = 1'b1;
      e.ld = 1'b1; e.imm = 16'(sv); e.ua = 1'b1;
    end else if (op == 4) begin
      e.dr = 3'(rt); e.sa = 3'(rs); e.sb = 3'(rt); e.mb = 1'b1;
      e.mw = 1'b1; e.imm = 16'(sv); e.ua = 1'b1; e.ub = 1'b1;
    end else if (op >= 5 && op <= 7) begin
      e.dr = 3'(rt); e.sa = 3'(rs); e.mb = 1'b1; e.ld = 1'b1;
      e.imm = 16'(sv); e.ua = 1'b1;
      e.fs = (op == 5) ? 3'd0 : (op == 6) ? 3'd5 : 3'd6;
    end else if (op >= 8 && op <= 11) begin
      e.sa = 3'(rs); e.sb = 3'(rt); e.fs = 3'd1;
      e.mb = (op >= 10); e.bs = 3'(op - 8); e.off = 16'(sv);
      e.ua = 1'b1; e.ub = 1'b1;
    end else begin
      e.dr = 3'(rd); e.sa = 3'(rs); e.sb = 3'(rt); e.fs = 3'(fn);
      e.ld = 1'b1; e.ua = 1'b1; e.ub = 1'b1;
    end
    return e;
  endfunction

  function automatic bit busy(input logic [2:0] r, input bit wbv,
                              input logic [2:0] wbd);
    return (pend[r] && !(wbv && wbd == r)) ||
           (mv && mh.ld && mh.dr == r);
  endfunction

  function automatic logic [15:0] enc(input int op, input int rs,
                                      input int rt, input int lo);
    return {4'(op), 3'(rs), 3'(rt), 6'(lo)};
  endfunction

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    mv = 1'b0;
    mh = '0;
    mhalt = 1'b0;
    mstall = 0;
    q.delete();
  endtask

  task automatic step(input bit v, input logic [15:0] w, input bit ordy,
                      input bit fl, input bit wbv,
                      input logic [2:0] wbd);
    exp_t d;
    bit hz, rdy, acc, hs;
    @(negedge clk);
    in_valid = v; inst = w; out_ready = ordy;
    flush = fl; wb_valid = wbv; wb_dr = wbd;
    #1;
    d = ref_decode(w);
    hz = (d.ua && busy(d.sa, wbv, wbd)) ||
         (d.ub && busy(d.sb, wbv, wbd)) ||
         (d.ld && busy(d.dr, wbv, wbd));
    rdy = !mhalt && !hz && !(mv && mh.hlt) && (!mv || ordy);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(mv));
    chk("halted", 64'(halted), 64'(mhalt));
    chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
    acc = v && rdy && !fl;
    hs = mv && ordy && !fl;
    if (wbv) pend[wbd] = 1'b0;
    if (hs && mh.ld) pend[mh.dr] = 1'b1;
    if (hs && mh.hlt) mhalt = 1'b1;
    if (v && hz && mstall < 65535) mstall++;
    if (fl) mv = 1'b0;
    else if (acc) mv = 1'b1;
    else if (hs) mv = 1'b0;
    if (acc) begin
      mh = d;
      q.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    wb_valid = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_wb_valid = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst fields", 64'({DR, SA, SB, FS, MB, MD, LD, MW, HLT}), 64'd0);
    chk("rst IMM/OFF", 64'({IMM, OFF}), 64'd0);
    chk("rst BS", 64'(BS), 64'd7);
    chk("rst halted/stall", 64'({halted, stall_cnt}), 64'd0);
    chk("rst wide", 64'({w_out_valid, w_BS}), 64'd7);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && (out_ready || flush)) begin
        if (q.size() == 0) begin
          chk("unexpected bundle", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("DR", 64'(DR), 64'(e.dr));
          chk("SA", 64'(SA), 64'(e.sa));
          chk("SB", 64'(SB), 64'(e.sb));
          chk("IMM", 64'(IMM), 64'(e.imm));
          chk("OFF", 64'(OFF), 64'(e.off));
          chk("FS", 64'(FS), 64'(e.fs));
          chk("BS", 64'(BS), 64'(e.bs));
          chk("MB/MD/LD/MW/HLT", 64'({MB, MD, LD, MW, HLT}),
              64'({e.mb, e.md, e.ld, e.mw, e.hlt}));
        end
      end
    end
  end

  initial begin : stim
    logic [15:0] hlt, rt2;
    rst_n = 1'b1;
    in_valid = 1'b0; inst = '0; out_ready = 1'b0; flush = 1'b0;
    wb_valid = 1'b0; wb_dr = '0;
    w_in_valid = 1'b0; w_inst = '0; w_out_ready = 1'b0;
    w_flush = 1'b0; w_wb_valid = 1'b0; w_wb_dr = '0;
    model_reset();
    do_reset();

    // ADDI r1,r0,#-3 then dependent R-type
    step(1, enc(5, 0, 1, 6'h3D), 0, 0, 0, 0);
    step(0, 16'd0, 1, 0, 0, 0);
    chk("addi DR", 64'(DR), 64'd1);
    chk("addi IMM", 64'(IMM), 64'hFFFD);
    chk("addi LD/MB", 64'({LD, MB}), 64'd3);
    rt2 = enc(15, 1, 3, 6'b010000);
    step(1, rt2, 1, 0, 0, 0);
    chk("raw stall", 64'(in_ready), 64'd0);
    step(1, rt2, 1, 0, 0, 0);
    step(1, rt2, 1, 0, 1, 1);
    chk("wb same-cycle accept", 64'(in_ready), 64'd1);
    chk("stall count", 64'(stall_cnt), 64'd2);
    step(0, 16'd0, 1, 0, 1, 2);
    step(1, enc(5, 2, 4, 0), 1, 0, 0, 0);
    chk("set beats clear", 64'(in_ready), 64'd0);
    step(0, 16'd0, 1, 0, 1, 2);

    // BNE r4,r5 with sign-extended negative offset
    step(1, enc(9, 4, 5, 6'h20), 0, 0, 0, 0);
    step(0, 16'd0, 1, 0, 0, 0);
    chk("bne OFF", 64'(OFF), 64'hFFE0);
    chk("bne BS/LD/IMM", 64'({BS, LD, IMM}), 64'({3'd1, 1'b0, 16'd0}));
    step(1, enc(5, 4, 5, 0), 1, 0, 0, 0);
    chk("bne no pending", 64'(in_ready), 64'd1);
    step(0, 16'd0, 1, 0, 1, 5);
    step(0, 16'd0, 0, 0, 1, 5);

    // flushed HLT, then replayed HLT
    hlt = enc(0, 0, 0, 1);
    step(1, hlt, 0, 0, 0, 0);
    step(0, 16'd0, 0, 1, 0, 0);
    step(0, 16'd0, 0, 0, 0, 0);
    chk("flush hlt", 64'({out_valid, halted}), 64'd0);
    step(1, hlt, 1, 0, 0, 0);
    step(0, 16'd0, 1, 0, 0, 0);
    step(1, 16'd0, 1, 0, 0, 0);
    chk("halted", 64'({halted, in_ready}), 64'b10);
    do_reset();

    // reset mid-stall with r1 pending and a bundle held
    step(1, enc(5, 0, 1, 1), 0, 0, 0, 0);
    step(0, 16'd0, 1, 0, 0, 0);
    step(1, enc(5, 0, 3, 0), 0, 0, 0, 0);
    step(1, enc(5, 1, 2, 0), 0, 0, 0, 0);
    chk("pre-reset stall", 64'(in_ready), 64'd0);
    do_reset();
    step(1, enc(5, 1, 2, 0), 1, 0, 0, 0);
    chk("post-reset accept", 64'(in_ready), 64'd1);

    for (int n = 0; n < 1500; n++) begin
      if (mhalt || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, 16'($urandom()),
             $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)));
      end
    end
    for (int n = 0; n < 3; n++) step(0, 16'd0, 1, 0, 0, 0);
    chk("queue drained", 64'(q.size()), 64'd0);

    // wide build, zero extension
    @(negedge clk);
    w_in_valid = 1'b1;
    w_inst = {4'h9, 4'd4, 4'd5, 7'b1000000};
    @(negedge clk);
    w_in_valid = 1'b0;
    #1;
    chk("w bne valid", 64'(w_out_valid), 64'd1);
    chk("w bne OFF", 64'(w_OFF), 64'h40);
    chk("w bne BS/LD/IMM", 64'({w_BS, w_LD, w_IMM}),
        64'({3'd1, 1'b0, 32'd0}));
    w_out_ready = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b1;
    w_inst = {4'h2, 4'd0, 4'd9, 7'd0};
    @(negedge clk);
    w_in_valid = 1'b0;
    @(negedge clk);
    w_in_valid = 1'b1;
    w_inst = {4'h4, 4'd9, 4'd1, 7'd0};
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("w sb stall", 64'(w_in_ready), 64'd0);
      @(negedge clk);
    end
    w_wb_valid = 1'b1;
    w_wb_dr = 4'd3;
    #1;
    chk("w wrong wb", 64'(w_in_ready), 64'd0);
    @(negedge clk);
    w_wb_dr = 4'd9;
    #1;
    chk("w wb9 accept", 64'(w_in_ready), 64'd1);
    @(negedge clk);
    w_in_valid = 1'b0;
    w_wb_valid = 1'b0;
    #1;
    chk("w sb bundle", 64'({w_out_valid, w_SA, w_MW}),
        64'({1'b1, 4'd9, 1'b1}));
    chk("w stall_cnt", 64'(w_stall_cnt), 64'd4);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
